// File: rtl/osc_freq_meter.sv
// osc_freq_meter: counts rising edges of one selected async oscillator over a gated clk window
// Ports: clk, rst (sync, active-high); osc_in[N_CH] async oscillators; ch_sel/gate_sel/mode_cont
// select channel, window G = GATE_BASE << gate_sel and continuous re-arm; start/abort control;
// busy (in GATE), done (1-cycle result pulse), count/ovf/ch_out hold the last completed window.
// Optional OSC_MINMAX_EN: stats_clr input, min_cnt/max_cnt running extremes of completed windows.
module osc_freq_meter #(
  parameter int N_CH = 4,
  parameter int CNT_W = 16,
  parameter int GATE_BASE = 1000,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  osc_in,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [1:0]       gate_sel,
  input  logic             mode_cont,
  input  logic             start,
  input  logic             abort,
`ifdef OSC_MINMAX_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] min_cnt,
  output logic [CNT_W-1:0] max_cnt,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic [CH_W-1:0]  ch_out
);
  localparam int WW = $clog2((GATE_BASE << 3) + 1);
  localparam logic [WW-1:0] GB = WW'(GATE_BASE);
  typedef enum logic {IDLE, GATE} state_t;
  state_t st;
  logic [N_CH-1:0] s1, s2, s3;
  logic [(1 << CH_W)-1:0] ep;
  logic [CH_W-1:0] ch_l;
  logic [WW-1:0] win, g;
  logic [CNT_W-1:0] cnt, nxt;
  logic acc, e, sat, nov, ld;
  // Edge vector padded to the full select range so unused codes read as a dead input.
  always_comb begin
    ep = '0;
    ep[N_CH-1:0] = s2 & ~s3;
    e = ep[ch_l];
    sat = &cnt;
    nxt = (e && !sat) ? cnt + 1'b1 : cnt;
    nov = acc | (e & sat);
    g = GB << gate_sel;
    ld = st == GATE && !abort && win == WW'(1);
  end
  assign busy = st == GATE;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      {s1, s2, s3} <= '0;
      ch_l <= '0;
      win <= '0;
      cnt <= '0;
      acc <= 1'b0;
      done <= 1'b0;
      count <= '0;
      ovf <= 1'b0;
      ch_out <= '0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
      done <= 1'b0;
      if (st == IDLE) begin
        if (start && !abort) begin
          ch_l <= ch_sel;
          win <= g;
          cnt <= '0;
          acc <= 1'b0;
          st <= GATE;
        end
      end else if (abort) begin
        st <= IDLE;
      end else if (ld) begin
        count <= nxt;
        ovf <= nov;
        ch_out <= ch_l;
        done <= 1'b1;
        cnt <= '0;
        acc <= 1'b0;
        if (mode_cont) begin
          ch_l <= ch_sel;
          win <= g;
        end else st <= IDLE;
      end else begin
        win <= win - 1'b1;
        cnt <= nxt;
        acc <= nov;
      end
    end
  end
`ifdef OSC_MINMAX_EN
  // A clear coincident with a result restarts the extremes from that result.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_cnt <= '1;
      max_cnt <= '0;
    end else if (ld) begin
      min_cnt <= (stats_clr || nxt < min_cnt) ? nxt : min_cnt;
      max_cnt <= (stats_clr || nxt > max_cnt) ? nxt : max_cnt;
    end else if (stats_clr) begin
      min_cnt <= '1;
      max_cnt <= '0;
    end
  end
`endif
endmodule

// File: tb/tb_osc_freq_meter.sv
// tb_osc_freq_meter: scoreboard bench for osc_freq_meter (N_CH=4, GATE_BASE=100, plus a CNT_W=8 copy)
`timescale 1ns/1ps
module tb_osc_freq_meter;
  typedef struct {int c; int o; int ch; int t;} exp_t;
  logic clk = 0, rst = 1, mode_cont = 0, start = 0, start8 = 0, abort = 0;
  logic [1:0] ch_sel = 0, gate_sel = 0;
  logic [3:0] osc;
  logic busy, done, ovf, busy8, done8, ovf8;
  logic [15:0] count;
  logic [7:0] count8;
  logic [1:0] ch_out, ch_out8;
`ifdef OSC_MINMAX_EN
  logic stats_clr = 0;
  logic [15:0] min_cnt, max_cnt;
  logic [7:0] min8, max8;
`endif
  int hp [4] = '{25, 50, 50, 20};
  int cyc = 0, bcnt = 0, acc = 0, errors = 0, checks = 0, b0;
  exp_t q[$], q8[$];
  exp_t x, x8;

  osc_freq_meter #(.N_CH(4), .CNT_W(16), .GATE_BASE(100)) dut (
    .clk(clk), .rst(rst), .osc_in(osc), .ch_sel(ch_sel), .gate_sel(gate_sel),
    .mode_cont(mode_cont), .start(start), .abort(abort),
`ifdef OSC_MINMAX_EN
    .stats_clr(stats_clr), .min_cnt(min_cnt), .max_cnt(max_cnt),
`endif
    .busy(busy), .done(done), .count(count), .ovf(ovf), .ch_out(ch_out));

  osc_freq_meter #(.N_CH(4), .CNT_W(8), .GATE_BASE(100)) dut8 (
    .clk(clk), .rst(rst), .osc_in(osc), .ch_sel(ch_sel), .gate_sel(gate_sel),
    .mode_cont(mode_cont), .start(start8), .abort(abort),
`ifdef OSC_MINMAX_EN
    .stats_clr(stats_clr), .min_cnt(min8), .max_cnt(max8),
`endif
    .busy(busy8), .done(done8), .count(count8), .ovf(ovf8), .ch_out(ch_out8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) bcnt <= bcnt + 1;

  for (genvar i = 0; i < 4; i++) begin : g
    logic o = 0;
    initial begin
      #3;
      forever #(hp[i]) o = ~o;
    end
    assign osc[i] = o;
  end

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  always @(negedge clk) if (!rst && done) begin
    if (q.size() == 0) chk("unexpected_done", 1, 0);
    else begin
      x = q.pop_front();
      chk("count", count, x.c);
      chk("ovf", ovf, x.o);
      chk("ch_out", ch_out, x.ch);
      if (x.t >= 0) chk("done_cycle", cyc, x.t);
    end
  end

  always @(negedge clk) if (!rst && done8) begin
    if (q8.size() == 0) chk("unexpected_done8", 1, 0);
    else begin
      x8 = q8.pop_front();
      chk("count8", count8, x8.c);
      chk("ovf8", ovf8, x8.o);
      chk("ch_out8", ch_out8, x8.ch);
      chk("done_cycle8", cyc, x8.t);
    end
  end

  task automatic go(input int ch, input int gs, input bit cont, input bit eight);
    @(negedge clk);
    ch_sel = 2'(ch);
    gate_sel = 2'(gs);
    mode_cont = cont;
    if (eight) start8 = 1; else start = 1;
    acc = cyc + 1;
    @(negedge clk);
    start = 0;
    start8 = 0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q8.size() != 0 || busy || busy8) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d want=0", q.size() + q8.size());
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d want=finish", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ch_out", ch_out, 0);
    chk("rst_count8", count8, 0);
`ifdef OSC_MINMAX_EN
    chk("rst_min", min_cnt, 65535);
    chk("rst_max", max_cnt, 0);
`endif
    rst = 0;
    repeat (5) @(negedge clk);
    go(1, 0, 0, 0);
    q.push_back('{10, 0, 1, acc + 100});
    drain();
    b0 = bcnt;
    go(3, 3, 0, 0);
    q.push_back('{200, 0, 3, acc + 800});
    drain();
    chk("busy_cycles", bcnt - b0, 800);
    hp[0] = 10;
    repeat (10) @(negedge clk);
    go(0, 3, 0, 1);
    q8.push_back('{255, 1, 0, acc + 800});
    drain();
    hp[0] = 25;
    repeat (10) @(negedge clk);
    go(2, 0, 1, 0);
    q.push_back('{10, 0, 2, acc + 100});
    q.push_back('{10, 0, 2, acc + 200});
    q.push_back('{20, 0, 0, acc + 300});
    wait_cyc(acc + 150);
    ch_sel = 0;
    wait_cyc(acc + 250);
    mode_cont = 0;
    drain();
    go(1, 0, 0, 0);
    wait_cyc(acc + 50);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    repeat (150) @(negedge clk);
    chk("abort_count_hold", count, 20);
    chk("abort_ch_hold", ch_out, 0);
    go(1, 0, 0, 0);
    wait_cyc(acc + 99);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_last_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("abort_last_count", count, 20);
    @(negedge clk);
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("start_abort_idle", busy, 0);
    go(3, 0, 0, 0);
    wait_cyc(acc + 30);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_ch_out", ch_out, 0);
    repeat (120) @(negedge clk);
    chk("midrst_idle", busy, 0);
`ifdef OSC_MINMAX_EN
    go(1, 0, 0, 0);
    q.push_back('{10, 0, 1, acc + 100});
    drain();
    hp[1] = 25;
    repeat (10) @(negedge clk);
    go(1, 0, 0, 0);
    q.push_back('{20, 0, 1, acc + 100});
    drain();
    hp[1] = 100;
    repeat (10) @(negedge clk);
    go(1, 0, 0, 0);
    q.push_back('{5, 0, 1, acc + 100});
    drain();
    chk("min_cnt", min_cnt, 5);
    chk("max_cnt", max_cnt, 20);
    hp[1] = 50;
    repeat (10) @(negedge clk);
    go(1, 0, 0, 0);
    q.push_back('{10, 0, 1, acc + 100});
    wait_cyc(acc + 99);
    stats_clr = 1;
    @(negedge clk);
    stats_clr = 0;
    drain();
    chk("clr_min", min_cnt, 10);
    chk("clr_max", max_cnt, 10);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
